mul_radix4_iter: RTL and testbench

//  Iterative radix-4 Booth multiplier for the RV32M/RV64M MUL/MULH/MULHSU/MULHU ops.

---
 rtl/mul_pkg.sv | 47 ++++
 rtl/mul_booth_enc.sv | 29 ++
 rtl/mul_radix4_iter.sv | 147 ++++++++++++++
 tb/tb_mul_radix4_iter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the iterative radix-4 Booth multiplier.
// Op encoding matches the RV32M/RV64M funct3 low bits for MUL/MULH/MULHSU/MULHU.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // Booth digits needed to cover the XLEN+2-bit extended multiplier.
  function automatic int calc_ndig(input int xlen);
    return xlen / 2 + 1;
  endfunction

  function automatic int calc_iter(input int xlen, input int dpc);
    return (calc_ndig(xlen) + dpc - 1) / dpc;
  endfunction

  function automatic booth_sel_e booth_decode(input logic [2:0] win);
    booth_sel_e sel;
    case (win)
      3'b001, 3'b010: sel = POS1;
      3'b011:         sel = POS2;
      3'b100:         sel = NEG2;
      3'b101, 3'b110: sel = NEG1;
      default:        sel = ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mul_booth_enc.sv
// Radix-4 Booth digit encoder: one 3-bit multiplier window selects
// 0, +-M or +-2M of the extended multiplicand as a signed partial product.
module mul_booth_enc
  import mul_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic        [2:0]    win_i,
  input  logic signed [XLEN+1:0] mcand_i,
  output logic signed [XLEN+2:0] pp_o
);

  logic signed [XLEN+2:0] m_ext;

  // |M| <= 2^XLEN, so +-2M always fits in XLEN+3 bits.
  assign m_ext = {mcand_i[XLEN+1], mcand_i};

  always_comb begin
    pp_o = '0;
    case (booth_decode(win_i))
      POS1:    pp_o = m_ext;
      POS2:    pp_o = m_ext <<< 1;
      NEG1:    pp_o = -m_ext;
      NEG2:    pp_o = -(m_ext <<< 1);
      default: pp_o = '0;
    endcase
  end

endmodule

// File: rtl/mul_radix4_iter.sv
// Iterative radix-4 Booth multiplier for MUL/MULH/MULHSU/MULHU with a
// valid/ready request side, held result, flush, zero early-out and tag pass-through.
module mul_radix4_iter
  import mul_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int DIGITS_PER_CYCLE = 2,
  parameter int TAG_W            = 5,
  parameter bit EARLY_ZERO       = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int D    = DIGITS_PER_CYCLE;
  localparam int NDIG = calc_ndig(XLEN);
  localparam int ITER = calc_iter(XLEN, DIGITS_PER_CYCLE);
  localparam int OW   = XLEN + 2;
  localparam int PW   = XLEN + 3;
  localparam int AW   = 2 * XLEN + 2;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  mul_state_e        state_q;
  logic              out_valid_q;
  logic [XLEN-1:0]   out_result_q;
  logic [TAG_W-1:0]  out_tag_q;
  logic [AW-1:0]     acc_q;
  logic [AW-1:0]     acc_sum;
  logic [CW-1:0]     cnt_q;
  logic signed [OW-1:0] mcand_q;
  // Bit 0 holds b[-1]; bit i holds multiplier bit i-1.
  logic [OW:0]       mplier_q;
  mul_op_e           op_q;

  logic              accept;
  logic              zero_hit;
  logic              rs1_signed;
  logic              rs2_signed;
  int                dig_base;
  logic signed [PW-1:0] pp [D];

  assign in_ready = rst_n && !flush &&
                    ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign zero_hit = EARLY_ZERO && ((in_rs1 == '0) || (in_rs2 == '0));

  assign rs1_signed = (in_op == MUL_OP_MULH) || (in_op == MUL_OP_MULHSU);
  assign rs2_signed = (in_op == MUL_OP_MULH);

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign busy       = (state_q != IDLE);

  // Index of the first Booth digit handled this cycle.
  assign dig_base = (ITER - 1 - int'(cnt_q)) * D;

  for (genvar j = 0; j < D; j++) begin : g_enc
    mul_booth_enc #(.XLEN(XLEN)) u_enc (
      .win_i   (mplier_q[2*j+2 : 2*j]),
      .mcand_i (mcand_q),
      .pp_o    (pp[j])
    );
  end

  // Digits past NDIG in the final pass contribute nothing.
  always_comb begin
    acc_sum = acc_q;
    for (int j = 0; j < D; j++) begin
      if (dig_base + j < NDIG) begin
        acc_sum = acc_sum + ({{(AW-PW){pp[j][PW-1]}}, pp[j]} << (2 * (dig_base + j)));
      end
    end
  end

  // Operand datapath: loaded on accept, multiplier consumed 2*D bits per pass.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q     <= mul_op_e'(in_op);
      mcand_q  <= {{2{rs1_signed & in_rs1[XLEN-1]}}, in_rs1};
      mplier_q <= {{2{rs2_signed & in_rs2[XLEN-1]}}, in_rs2, 1'b0};
    end else if (state_q == BUSY) begin
      mplier_q <= mplier_q >> (2 * D);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
    end else if (flush) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        BUSY: begin
          acc_q <= acc_sum;
          if (cnt_q == '0) begin
            state_q      <= DONE;
            out_valid_q  <= 1'b1;
            out_result_q <= (op_q == MUL_OP_MUL) ? acc_sum[XLEN-1:0]
                                                 : acc_sum[2*XLEN-1:XLEN];
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          if ((state_q == DONE) && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
          // A back-to-back accept from DONE overrides the return to IDLE.
          if (accept) begin
            acc_q     <= '0;
            cnt_q     <= CW'(ITER - 1);
            out_tag_q <= in_tag;
            if (zero_hit) begin
              state_q      <= DONE;
              out_valid_q  <= 1'b1;
              out_result_q <= '0;
            end else begin
              state_q     <= BUSY;
              out_valid_q <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_radix4_iter.sv
// Bench for mul_radix4_iter: directed corner products, latency, backpressure,
// flush and mid-op reset, then a random sweep checked against a plain product model.
module tb_mul_radix4_iter;

  localparam int XLEN  = 32;
  localparam int D     = 2;
  localparam int TAG_W = 5;
  localparam int ITER  = (XLEN / 2 + 1 + D - 1) / D;
  localparam int LIMIT = 500;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_op = 2'b00;
  logic [XLEN-1:0]  in_rs1 = '0;
  logic [XLEN-1:0]  in_rs2 = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  typedef struct {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
  } sb_entry_t;

  sb_entry_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;
  bit rand_rdy = 1'b0;

  mul_radix4_iter #(
    .XLEN(XLEN), .DIGITS_PER_CYCLE(D), .TAG_W(TAG_W), .EARLY_ZERO(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [XLEN-1:0] ref_mul(input logic [1:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] ae, be, p;
    ae = (op == 2'b01 || op == 2'b10) ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
    be = (op == 2'b01) ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    p  = ae * be;
    return (op == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] pick();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return XLEN'(1);
      2:       return '1;
      3:       return XLEN'(1) << (XLEN - 1);
      default: return XLEN'(r);
    endcase
  endfunction

  // Scoreboard consumer: every handshaken result must match the oldest expectation.
  always @(negedge clk) begin
    sb_entry_t e;
    if (rst_n && out_valid && out_ready) begin
      check("sb_has_entry", 64'(sb.size() > 0), 64'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("result", 64'(out_result), 64'(e.res));
        check("tag", 64'(out_tag), 64'(e.tag));
      end
    end
  end

  // Starts and ends one time unit after a rising edge; returns cycles waited for in_ready.
  task automatic send(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] exp, output int waits);
    bit got;
    got = 1'b0;
    in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_tag = tag;
    for (waits = 0; waits < LIMIT; waits++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 1) == 1);
    end
    check("accept_seen", 64'(got), 64'(1));
    if (got) sb.push_back('{exp, tag});
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_op  = 2'($urandom_range(0, 3));
    in_rs1 = XLEN'({$urandom(), $urandom()});
    in_rs2 = XLEN'({$urandom(), $urandom()});
  endtask

  task automatic wait_valid(output int n);
    for (n = 1; n <= LIMIT; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
  endtask

  task automatic run_lat(input string name, input logic [1:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag,
                         input logic [XLEN-1:0] exp, input int exp_lat);
    int w, n;
    send(op, a, b, tag, exp, w);
    wait_valid(n);
    check(name, 64'(n), 64'(exp_lat));
    @(posedge clk); #1;
  endtask

  initial begin
    int w, n, cnt;
    logic [XLEN-1:0] ones, msb, a, b;
    logic [1:0] op;
    logic [TAG_W-1:0] tg;
    int fc, rc;

    ones = '1;
    msb  = XLEN'(1) << (XLEN - 1);
    fc   = (ITER >= 4) ? 4 : 1;
    rc   = (ITER >= 3) ? 3 : 1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_result", 64'(out_result), 64'(0));
    check("rst_tag", 64'(out_tag), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    // Directed corner products
    run_lat("lat_mulhu", 2'b11, ones, ones, 5'd1, ones - XLEN'(1), ITER + 1);
    run_lat("lat_mulh", 2'b01, msb, msb, 5'd2, XLEN'(1) << (XLEN - 2), ITER + 1);
    run_lat("lat_mul_msb", 2'b00, msb, msb, 5'd3, '0, ITER + 1);
    run_lat("lat_mulhsu", 2'b10, ones, ones, 5'd4, ones, ITER + 1);
    run_lat("lat_mul_ones", 2'b00, ones, ones, 5'd5, XLEN'(1), ITER + 1);
    run_lat("lat_zero", 2'b00, '0, XLEN'(32'h12345678), 5'd7, '0, 1);

    // Backpressure: result held, no accept, then same-cycle accept on release
    out_ready = 1'b0;
    send(2'b00, XLEN'(32'h1234), XLEN'(16), 5'd9, XLEN'(32'h12340), w);
    wait_valid(n);
    check("lat_bp", 64'(n), 64'(ITER + 1));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'(1));
      check("bp_result", 64'(out_result), 64'(32'h12340));
      check("bp_tag", 64'(out_tag), 64'(9));
      check("bp_in_ready", 64'(in_ready), 64'(0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    a = XLEN'(32'hDEADBEEF); b = XLEN'(32'h00000003);
    send(2'b11, a, b, 5'd10, XLEN'(2), w);
    check("b2b_accept_wait", 64'(w), 64'(0));
    wait_valid(n);
    check("lat_b2b", 64'(n), 64'(ITER + 1));
    @(posedge clk); #1;

    // Flush mid-operation with a competing request
    send(2'b01, XLEN'(32'h7FFFFFFF), XLEN'(32'h7FFFFFFF), 5'd11, XLEN'(32'h3FFFFFFF), w);
    repeat (fc - 1) begin @(posedge clk); #1; end
    flush = 1'b1; in_valid = 1'b1; in_op = 2'b00; in_rs1 = XLEN'(5); in_rs2 = XLEN'(6);
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'(0));
    void'(sb.pop_back());
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_busy", 64'(busy), 64'(0));
    check("flush_valid", 64'(out_valid), 64'(0));
    cnt = 0;
    repeat (ITER + 2) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("flush_silent", 64'(cnt), 64'(0));
    @(posedge clk); #1;
    run_lat("lat_post_flush", 2'b00, XLEN'(1000), XLEN'(1000), 5'd12, XLEN'(1000000), ITER + 1);

    // Reset mid-operation
    send(2'b11, ones, ones, 5'd13, ones - XLEN'(1), w);
    repeat (rc - 1) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    check("mrst_busy", 64'(busy), 64'(0));
    check("mrst_valid", 64'(out_valid), 64'(0));
    check("mrst_result", 64'(out_result), 64'(0));
    check("mrst_tag", 64'(out_tag), 64'(0));
    @(posedge clk); #1;
    run_lat("lat_post_rst", 2'b10, ones, XLEN'(2), 5'd14, ones, ITER + 1);

    // Random sweep with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      tg = TAG_W'($urandom());
      send(op, a, b, tg, ref_mul(op, a, b), w);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 1) == 1);
      end
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4 * (ITER + 2) && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    check("drain", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
